// File: rtl/sc_shiftseq_reg.sv
// Multi-cycle shift register sequencer: clear/load/start in IDLE, one 1-bit step per SHIFT cycle, DONE pulse.
// Rotate modes (100 ROL, 101 ROR) exist only when SC_SHIFTSEQ_ROTATE_EN is defined; otherwise they hold.
module sc_shiftseq_reg #(
    parameter int unsigned SHIFTSEQ_DATAWIDTH   = 8,
    parameter int unsigned SHIFTSEQ_AMOUNTWIDTH = 3
) (
    input  logic                            SC_SHIFTSEQ_CLOCK_50,
    input  logic                            SC_SHIFTSEQ_RESET_InLow,
    input  logic                            SC_SHIFTSEQ_clear_InLow,
    input  logic                            SC_SHIFTSEQ_load_InLow,
    input  logic                            SC_SHIFTSEQ_start_In,
    input  logic [2:0]                      SC_SHIFTSEQ_mode_In,
    input  logic [SHIFTSEQ_AMOUNTWIDTH-1:0] SC_SHIFTSEQ_amount_In,
    input  logic                            SC_SHIFTSEQ_serial_In,
    input  logic [SHIFTSEQ_DATAWIDTH-1:0]   SC_SHIFTSEQ_data_InBUS,
    output logic [SHIFTSEQ_DATAWIDTH-1:0]   SC_SHIFTSEQ_data_OutBUS,
    output logic                            SC_SHIFTSEQ_busy_Out,
    output logic                            SC_SHIFTSEQ_done_Out
);

    localparam int unsigned W  = SHIFTSEQ_DATAWIDTH;
    localparam int unsigned AW = SHIFTSEQ_AMOUNTWIDTH;

    localparam logic [2:0] MODE_LSL = 3'b001;
    localparam logic [2:0] MODE_LSR = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
`ifdef SC_SHIFTSEQ_ROTATE_EN
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [2:0]      mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // One 1-bit step of the latched mode; unknown/disabled codes hold.
    function automatic logic [W-1:0] shift_step(input logic [W-1:0] r,
                                                input logic [2:0]   m,
                                                input logic         s);
        logic [W-1:0] res;
        res = r;
        case (m)
            MODE_LSL: res = {r[W-2:0], s};
            MODE_LSR: res = {s, r[W-1:1]};
            MODE_ASR: res = {r[W-1], r[W-1:1]};
`ifdef SC_SHIFTSEQ_ROTATE_EN
            MODE_ROL: res = {r[W-2:0], r[W-1]};
            MODE_ROR: res = {r[0], r[W-1:1]};
`endif
            default:  res = r;
        endcase
        return res;
    endfunction

    // State register
    always_ff @(posedge SC_SHIFTSEQ_CLOCK_50) begin
        if (!SC_SHIFTSEQ_RESET_InLow) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over everything except reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!SC_SHIFTSEQ_clear_InLow || !SC_SHIFTSEQ_load_InLow) begin
                    state_d = ST_IDLE;
                end else if (SC_SHIFTSEQ_start_In) begin
                    state_d = (SC_SHIFTSEQ_amount_In == AW'(0)) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!SC_SHIFTSEQ_clear_InLow) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and flag next values
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (!SC_SHIFTSEQ_clear_InLow) begin
                    data_d = '0;
                end else if (!SC_SHIFTSEQ_load_InLow) begin
                    data_d = SC_SHIFTSEQ_data_InBUS;
                end else if (SC_SHIFTSEQ_start_In) begin
                    mode_d = SC_SHIFTSEQ_mode_In;
                    cnt_d  = SC_SHIFTSEQ_amount_In;
                end
            end
            ST_SHIFT: begin
                if (!SC_SHIFTSEQ_clear_InLow) begin
                    data_d = '0;
                    cnt_d  = '0;
                end else begin
                    data_d = shift_step(data_q, mode_q, SC_SHIFTSEQ_serial_In);
                    cnt_d  = cnt_q - AW'(1);
                end
            end
            ST_DONE: begin
                if (!SC_SHIFTSEQ_clear_InLow) begin
                    data_d = '0;
                end
            end
            default: begin
                data_d = data_q;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge SC_SHIFTSEQ_CLOCK_50) begin
        if (!SC_SHIFTSEQ_RESET_InLow) begin
            data_q <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign SC_SHIFTSEQ_data_OutBUS = data_q;
    assign SC_SHIFTSEQ_busy_Out    = busy_q;
    assign SC_SHIFTSEQ_done_Out    = done_q;

endmodule

// File: tb/tb_sc_shiftseq_reg.sv
// Randomized self-checking bench for sc_shiftseq_reg (8-bit data, 4-bit amount so amounts >= width occur).
// Honours SC_SHIFTSEQ_ROTATE_EN in its reference model.
module tb_sc_shiftseq_reg;

    logic       clk;
    logic       rst_n;
    logic       clear_n;
    logic       load_n;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic       serial;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_reg = 8'h00;

`ifdef SC_SHIFTSEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    sc_shiftseq_reg #(
        .SHIFTSEQ_DATAWIDTH  (8),
        .SHIFTSEQ_AMOUNTWIDTH(4)
    ) dut (
        .SC_SHIFTSEQ_CLOCK_50   (clk),
        .SC_SHIFTSEQ_RESET_InLow(rst_n),
        .SC_SHIFTSEQ_clear_InLow(clear_n),
        .SC_SHIFTSEQ_load_InLow (load_n),
        .SC_SHIFTSEQ_start_In   (start),
        .SC_SHIFTSEQ_mode_In    (mode),
        .SC_SHIFTSEQ_amount_In  (amount),
        .SC_SHIFTSEQ_serial_In  (serial),
        .SC_SHIFTSEQ_data_InBUS (din),
        .SC_SHIFTSEQ_data_OutBUS(dout),
        .SC_SHIFTSEQ_busy_Out   (busy),
        .SC_SHIFTSEQ_done_Out   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: one step expressed as arithmetic on the register value
    function automatic logic [7:0] model_step(input logic [7:0] r, input logic [2:0] m, input logic s);
        case (m)
            3'd1: return 8'(r << 1) | {7'b0, s};
            3'd2: return (r >> 1) | (s ? 8'h80 : 8'h00);
            3'd3: return (r >> 1) | (r & 8'h80);
            3'd4: return ROT_EN ? (8'(r << 1) | (r >> 7)) : r;
            3'd5: return ROT_EN ? ((r >> 1) | (r[0] ? 8'h80 : 8'h00)) : r;
            default: return r;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        clear_n = 1'b1; load_n = 1'b1; start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        idle_inputs();
        load_n = 1'b0; din = v;
        tick();
        load_n = 1'b1;
        exp_reg = v;
        checks++;
        if (dout !== exp_reg || busy !== 1'b0) begin
            errors++;
            $display("FAIL load data=%h busy=%b exp data=%h busy=0", dout, busy, exp_reg);
        end
    endtask

    // Starts a shift and follows it cycle by cycle; smode 0/1 = fixed serial, 2 = random per cycle
    task automatic run_shift(input logic [2:0] m, input int n, input int smode, input string name);
        idle_inputs();
        mode = m; amount = 4'(n); start = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy cycle %0d busy=%b done=%b exp busy=1 done=0", name, k, busy, done);
            end
            serial = (smode == 2) ? 1'($urandom_range(0, 1)) : 1'(smode);
            load_n = 1'($urandom_range(0, 1));
            start  = 1'($urandom_range(0, 1));
            din    = 8'($urandom);
            mode   = 3'($urandom);
            amount = 4'($urandom);
            tick();
            exp_reg = model_step(exp_reg, m, serial);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || dout !== exp_reg) begin
            errors++;
            $display("FAIL %s done cycle busy=%b done=%b data=%h exp busy=0 done=1 data=%h",
                     name, busy, done, dout, exp_reg);
        end
        start = 1'b1; load_n = 1'b0; din = ~exp_reg; amount = 4'($urandom_range(1, 15));
        tick();
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== exp_reg) begin
            errors++;
            $display("FAIL %s after done busy=%b done=%b data=%h exp busy=0 done=0 data=%h",
                     name, busy, done, dout, exp_reg);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; idle_inputs();
        mode = 3'd0; amount = 4'd0; serial = 1'b0; din = 8'hFF; load_n = 1'b0;
        tick(); tick();
        checks++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset data=%h busy=%b done=%b exp 00/0/0", dout, busy, done);
        end
        rst_n = 1'b1; idle_inputs();
        tick();
        exp_reg = 8'h00;
    endtask

    task automatic test_vectors;
        do_load(8'h81);
        run_shift(3'd1, 3, 1, "lsl3");
        checks++;
        if (dout !== 8'h0F) begin
            errors++; $display("FAIL lsl3_vec data=%h exp 0f", dout);
        end
        do_load(8'h80);
        run_shift(3'd3, 2, 0, "asr2");
        checks++;
        if (dout !== 8'hE0) begin
            errors++; $display("FAIL asr2_vec data=%h exp e0", dout);
        end
        run_shift(3'd2, 1, 0, "lsr1");
        checks++;
        if (dout !== 8'h70) begin
            errors++; $display("FAIL lsr1_vec data=%h exp 70", dout);
        end
        do_load(8'h96);
        run_shift(3'd5, 4, 2, "ror4");
        checks++;
        if (dout !== (ROT_EN ? 8'h69 : 8'h96)) begin
            errors++; $display("FAIL ror4_vec data=%h exp %h", dout, ROT_EN ? 8'h69 : 8'h96);
        end
        do_load(8'h3C);
        run_shift(3'd4, 8, 2, "rol8");
        checks++;
        if (dout !== 8'h3C) begin
            errors++; $display("FAIL rol8_vec data=%h exp 3c", dout);
        end
    endtask

    task automatic test_zero_amount;
        do_load(8'h5B);
        run_shift(3'd1, 0, 1, "amt0");
        checks++;
        if (dout !== 8'h5B) begin
            errors++; $display("FAIL amt0_data data=%h exp 5b", dout);
        end
    endtask

    task automatic test_priority;
        idle_inputs();
        clear_n = 1'b0; load_n = 1'b0; din = 8'h5A; start = 1'b1; amount = 4'd3; mode = 3'd1;
        tick();
        checks++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL clear_prio data=%h busy=%b done=%b exp 00/0/0", dout, busy, done);
        end
        clear_n = 1'b1;
        tick();
        checks++;
        if (dout !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL load_prio data=%h busy=%b done=%b exp 5a/0/0", dout, busy, done);
        end
        idle_inputs();
        tick();
        exp_reg = 8'h5A;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== exp_reg) begin
            errors++; $display("FAIL load_prio_idle busy=%b done=%b data=%h exp 0/0/5a", busy, done, dout);
        end
    endtask

    task automatic test_clear_abort;
        logic [7:0] v;
        v = 8'($urandom) | 8'h01;
        do_load(v);
        mode = 3'd1; amount = 4'd5; start = 1'b1;
        tick();
        serial = 1'b1; load_n = 1'b0; din = 8'hAA; start = 1'b1; mode = 3'd2; amount = 4'd1;
        tick();
        exp_reg = model_step(exp_reg, 3'd1, 1'b1);
        checks++;
        if (dout !== exp_reg || busy !== 1'b1) begin
            errors++; $display("FAIL abort_step1 data=%h busy=%b exp %h/1", dout, busy, exp_reg);
        end
        clear_n = 1'b0;
        tick();
        idle_inputs();
        exp_reg = 8'h00;
        checks++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort data=%h busy=%b done=%b exp 00/0/0", dout, busy, done);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL abort_after %0d data=%h busy=%b done=%b exp 00/0/0", k, dout, busy, done);
            end
        end
    endtask

    task automatic test_reset_midshift;
        do_load(8'hA5);
        mode = 3'd0; amount = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (dout !== 8'hA5 || busy !== 1'b1) begin
            errors++; $display("FAIL midshift_pre data=%h busy=%b exp a5/1", dout, busy);
        end
        rst_n = 1'b0; load_n = 1'b0; din = 8'hFF; start = 1'b1;
        tick();
        checks++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midshift_reset data=%h busy=%b done=%b exp 00/0/0", dout, busy, done);
        end
        rst_n = 1'b1; idle_inputs();
        tick(); tick();
        exp_reg = 8'h00;
        checks++;
        if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL post_reset data=%h busy=%b done=%b exp 00/0/0", dout, busy, done);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            run_shift(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 2, "rand");
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_n = 1'b1; load_n = 1'b1; start = 1'b0;
        mode = 3'd0; amount = 4'd0; serial = 1'b0; din = 8'h00;
        test_reset();
        test_vectors();
        test_zero_amount();
        test_priority();
        test_clear_abort();
        test_reset_midshift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_shiftseq_reg.md
SC_SHIFTSEQ_REG -- requirements
Module: sc_shiftseq_reg

Interface
REQ-001 SHALL provide parameter SHIFTSEQ_DATAWIDTH, default 8, meaning register width in bits (>=2).
REQ-002 SHALL provide parameter SHIFTSEQ_AMOUNTWIDTH, default 3, meaning width of the shift-amount field.
REQ-003 SHALL provide port SC_SHIFTSEQ_CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port SC_SHIFTSEQ_RESET_InLow  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide port SC_SHIFTSEQ_clear_InLow  input  1  synchronous clear request, active-low.
REQ-006 SHALL provide port SC_SHIFTSEQ_load_InLow  input  1  parallel load request, active-low.
REQ-007 SHALL provide port SC_SHIFTSEQ_start_In  input  1  start a multi-cycle shift, active-high.
REQ-008 SHALL provide port SC_SHIFTSEQ_mode_In  input  3  shift mode: 000 hold, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 110/111 hold.
REQ-009 SHALL provide port SC_SHIFTSEQ_amount_In  input  SHIFTSEQ_AMOUNTWIDTH  number of one-bit shift steps.
REQ-010 SHALL provide port SC_SHIFTSEQ_serial_In  input  1  fill bit for LSL/LSR.
REQ-011 SHALL provide port SC_SHIFTSEQ_data_InBUS  input  SHIFTSEQ_DATAWIDTH  parallel load data.
REQ-012 SHALL provide port SC_SHIFTSEQ_data_OutBUS  output  SHIFTSEQ_DATAWIDTH  registered contents.
REQ-013 SHALL provide port SC_SHIFTSEQ_busy_Out  output  1  high while in SHIFT state.
REQ-014 SHALL provide port SC_SHIFTSEQ_done_Out  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE, all state and outputs registered; data_OutBUS is the register directly.
REQ-016 In IDLE, priority SHALL be clear (register<=0) > load (register<=data_InBUS) > start > hold; state stays IDLE for clear/load.
REQ-017 On start in IDLE, SHALL latch mode_In and amount_In; amount=0 -> DONE next cycle, register unchanged; amount>0 -> SHIFT.
REQ-018 In SHIFT, SHALL perform exactly one one-bit step per cycle and decrement the latched count; after the step with count=1, next state DONE.
REQ-019 Latency: start with amount N>0 -> busy high N cycles, done high in cycle N+1 after start edge; data final when done is high.
REQ-020 LSL: {reg[W-2:0],serial_In}; LSR: {serial_In,reg[W-1:1]}; ASR: {reg[W-1],reg[W-1:1]}; ROL: {reg[W-2:0],reg[W-1]}; ROR: {reg[0],reg[W-1:1]}; hold codes: unchanged, timing identical.
REQ-021 serial_In SHALL be sampled live each SHIFT cycle, not latched.
REQ-022 DONE SHALL last exactly one cycle then return to IDLE; start in DONE is ignored.
REQ-023 During SHIFT/DONE, load and start SHALL be ignored and mode_In/amount_In changes SHALL have no effect.
REQ-024 clear_InLow low in SHIFT or DONE SHALL abort: register<=0, state<=IDLE, busy and done low next cycle, no done pulse.
REQ-025 Amounts >= SHIFTSEQ_DATAWIDTH SHALL be honoured step-by-step (e.g. ROL by W returns original value).

Reset
REQ-026 RESET_InLow low at a clock edge SHALL force register=0, state=IDLE, busy=0, done=0, latched count=0, overriding all other inputs including mid-shift.
REQ-027 Reset SHALL have no asynchronous effect; outputs change only on clock edges.

Configuration
REQ-028 Macro SC_SHIFTSEQ_ROTATE_EN SHALL gate rotate support.
REQ-029 With SC_SHIFTSEQ_ROTATE_EN defined, modes 100/101 SHALL perform ROL/ROR per REQ-020.
REQ-030 Without it, modes 100/101 SHALL behave as hold (register unchanged, busy/done timing unchanged) and no rotate logic is synthesised.

Verification
REQ-031 Reset low mid-SHIFT with reg=8'hA5 -> next edge reg=8'h00, busy=0, done=0.
REQ-032 load 8'h81, start LSL amount=3 serial_In=1 -> busy 3 cycles, done pulse, reg=8'h0F.
REQ-033 load 8'h80, start ASR amount=2 -> reg=8'hE0; then LSR amount=1 serial_In=0 -> reg=8'h70.
REQ-034 load 8'h96, start ROR amount=4 -> reg=8'h69 with ROTATE_EN; reg=8'h96 without, same busy/done timing.
REQ-035 start amount=0 -> busy never high, done high next cycle, reg unchanged.
REQ-036 clear_InLow low in 2nd SHIFT cycle of amount=5, plus load/start pulses during SHIFT -> loads/starts ignored, reg=0, IDLE, no done pulse.
